// File: rtl/shared_arith_slave.sv
// ---------------------------------------------------------------------------
// shared_arith_slave
//   Shared execution unit behind the two-master arbiter. Accepts one
//   operation per S_req/S_ack transaction: Select=0 adds, Select=1 runs an
//   iterative shift-add multiply (one multiplier bit per cycle, LSB first).
//   Results are unsigned modular; S_ovf reports carry-out (add) or any
//   non-zero upper product half (multiply).
//
// Ports
//   CLK        in   clock, rising edge
//   RSTn       in   asynchronous active-low reset
//   S_req      in   request from arbiter, held until S_ack
//   Select     in   0 = add, 1 = multiply (sampled at accept)
//   S_Data1    in   operand A (sampled at accept)
//   S_Data2    in   operand B (sampled at accept)
//   S_Dataout  out  result, held until the next completed operation
//   S_ack      out  registered one-cycle completion pulse
//   S_ovf      out  overflow flag of the last completed operation
//   S_busy     out  high while an operation is executing or completing
// ---------------------------------------------------------------------------
module shared_arith_slave #(
   parameter int WIDTH = 25,
   parameter int CNT_W = 5
) (
   input  logic             CLK,
   input  logic             RSTn,
   input  logic             S_req,
   input  logic             Select,
   input  logic [WIDTH-1:0] S_Data1,
   input  logic [WIDTH-1:0] S_Data2,
   output logic [WIDTH-1:0] S_Dataout,
   output logic             S_ack,
   output logic             S_ovf,
   output logic             S_busy
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      EXEC_ADD = 2'd1,
      EXEC_MUL = 2'd2,
      DONE     = 2'd3
   } state_t;

   state_t state, next_state;

   // a_q is 2*WIDTH wide so it doubles as the left-shifting multiplicand;
   // the add path only uses its low WIDTH bits.
   logic [2*WIDTH-1:0] a_q;
   logic [WIDTH-1:0]   b_q;
   logic [2*WIDTH-1:0] acc;
   logic [CNT_W-1:0]   cnt;

   logic [WIDTH:0]     add_sum;
   logic [2*WIDTH-1:0] mul_sum;

   assign add_sum = {1'b0, a_q[WIDTH-1:0]} + {1'b0, b_q};
   // Partial-product accumulation for the current multiplier bit.
   assign mul_sum = acc + (b_q[0] ? a_q : '0);

   assign S_busy = (state != IDLE);

   // State register
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (S_req) begin
               next_state = Select ? EXEC_MUL : EXEC_ADD;
            end
         end
         EXEC_ADD: begin
            next_state = S_req ? DONE : IDLE;
         end
         EXEC_MUL: begin
            if (!S_req) begin
               next_state = IDLE;
            end else if (cnt == '0) begin
               next_state = DONE;
            end
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Datapath and registered outputs
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         a_q       <= '0;
         b_q       <= '0;
         acc       <= '0;
         cnt       <= '0;
         S_Dataout <= '0;
         S_ovf     <= 1'b0;
         S_ack     <= 1'b0;
      end else begin
         // Ack is decoded from the state being entered, so it is a clean
         // flop output that is high exactly while in DONE.
         S_ack <= (next_state == DONE);
         case (state)
            IDLE: begin
               if (S_req) begin
                  a_q <= {{WIDTH{1'b0}}, S_Data1};
                  b_q <= S_Data2;
                  acc <= '0;
                  cnt <= CNT_W'(WIDTH - 1);
               end
            end
            EXEC_ADD: begin
               if (S_req) begin
                  S_Dataout <= add_sum[WIDTH-1:0];
                  S_ovf     <= add_sum[WIDTH];
               end
            end
            EXEC_MUL: begin
               if (S_req) begin
                  acc <= mul_sum;
                  a_q <= a_q << 1;
                  b_q <= b_q >> 1;
                  cnt <= cnt - 1'b1;
                  if (cnt == '0) begin
                     S_Dataout <= mul_sum[WIDTH-1:0];
                     S_ovf     <= |mul_sum[2*WIDTH-1:WIDTH];
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: doc/shared_arith_slave.md
Name: shared_arith_slave

Overview:
- Shared slave execution unit behind the two-master arbiter (M1 = adder client, M2 = multiplier client). It sits directly downstream of the arbiter and drives its slave-side handshake.
- It accepts one operation per S_req/S_ack transaction. Select picks the operation: 0 = add, 1 = multiply.
- It returns a WIDTH-bit result with a single-cycle S_ack pulse.
- Add is single-cycle. Multiply is an iterative shift-add unit, so one multiplier datapath is shared by both masters.

Parameters:
- WIDTH, 25, operand/result width; matches the arbiter data buses.
- CNT_W, 5, multiply iteration counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RSTn  in  1  asynchronous active-low reset.
- S_req  in  1  request from the arbiter; held high until S_ack, may drop combinationally in the S_ack cycle.
- Select  in  1  operation select, 0 = add, 1 = multiply; sampled only at accept.
- S_Data1  in  WIDTH  operand A; sampled only at accept.
- S_Data2  in  WIDTH  operand B; sampled only at accept.
- S_Dataout  out  WIDTH  result; feeds the arbiter's S_Datain.
- S_ack  out  1  registered completion pulse; high for exactly one cycle.
- S_ovf  out  1  overflow flag for the operation just completed; valid with S_ack.
- S_busy  out  1  high while in EXEC or DONE.

Behaviour:
- Reset (RSTn low, asynchronous): state IDLE; S_Dataout=0, S_ack=0, S_ovf=0, S_busy=0; operand registers, accumulator and counter cleared. Reset wins over any operation in flight; no ack is produced for it.
- States:
  - IDLE.
  - EXEC_ADD.
  - EXEC_MUL.
  - DONE.
- IDLE: on an edge with S_req=1, capture S_Data1, S_Data2 and Select.
  - Select=0 -> EXEC_ADD.
  - Select=1 -> EXEC_MUL; accumulator cleared, counter = WIDTH-1.
  - S_req=0 -> stay in IDLE.
- EXEC_ADD: compute {carry, sum} = A + B, width WIDTH+1. Next edge registers S_Dataout = sum[WIDTH-1:0], S_ovf = carry; -> DONE.
- EXEC_MUL: one multiplier bit per cycle, LSB first. The accumulator is 2*WIDTH bits: if B[i]=1 add A<<i; counter decrements.
  - On the edge where counter = 0: S_Dataout = product[WIDTH-1:0], S_ovf = |product[2*WIDTH-1:WIDTH]; -> DONE.
  - EXEC_MUL lasts exactly WIDTH cycles.
- DONE: S_ack=1 (registered, state-decoded) for exactly one cycle, S_ack is asserted regardless of S_req; -> IDLE on the next edge. No new accept can occur in the DONE cycle.
- Latency from the accept edge:
  - add: S_ack high in the 2nd cycle after accept.
  - mul: S_ack high in the (WIDTH+1)th cycle after accept (26 cycles at default).
- Abort: S_req sampled low on any edge in EXEC_ADD/EXEC_MUL -> IDLE. No S_ack; S_Dataout and S_ovf keep their previous values.
- Mid-operation changes to Select, S_Data1 or S_Data2 are ignored.
- Result hold: S_Dataout and S_ovf hold until the next completed operation.
- Back-to-back: a new S_req may be accepted on the first IDLE edge after DONE. The arbiter guarantees at least one S_req-low cycle between transactions, but the slave does not depend on it.
- Arithmetic: unsigned modular, no rounding, no saturation.
- S_busy = (state != IDLE).

Test Plan:
- Add: reset, then S_req=1, Select=0, A=100, B=23 -> S_ack pulses once in the 2nd cycle after accept, S_Dataout=123, S_ovf=0, S_busy low one cycle after ack.
- Add overflow: A=0x1FFFFFF, B=1 -> S_Dataout=0, S_ovf=1; next transaction A=5, B=7 -> S_Dataout=12, S_ovf=0.
- Multiply: Select=1, A=1000, B=3000 -> S_ack exactly 26 cycles after accept, S_Dataout=3000000, S_ovf=0. A=0x1000 (2^12), B=0x2000 (2^13) -> S_Dataout=0, S_ovf=1.
- Abort: start multiply A=7, B=9, drop S_req at cycle 10 -> no S_ack within 40 cycles, S_Dataout unchanged. A following add of 2+3 -> 5 with normal latency.
- Reset mid-operation: assert RSTn low asynchronously (between edges) during EXEC_MUL -> all outputs 0 immediately, no ack after release. Toggling Select/S_Data1 during EXEC_MUL (no reset) has no effect on the result.
- Back-to-back alternating masters (add then mul, one idle cycle between) with S_req dropped combinationally on S_ack -> exactly one S_ack per transaction, correct results 123 then 3000000.
